// File: rtl/rename_in_receiver.sv
// rename_in_receiver
// Receiving end of the rename-in interface. Maps the architectural sources
// and destination of one decoded instruction per cycle through a
// speculative RAT, allocates a new physical destination from a circular
// free list, and registers the renamed uop in a one-entry output stage.
// Commit updates the committed RAT and returns the old mapping to the free
// list. Flush restores the speculative RAT and head from committed state.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            decode handshake
//   in_rs1, in_rs2, in_rd        architectural registers
//   in_rd_wen                    instruction writes in_rd
//   out_valid/out_ready          dispatch handshake
//   out_prs1, out_prs2           physical sources
//   out_prd, out_old_prd         new and previous physical destination
//   out_rd_wen                   effective write enable (rd != x0)
//   cmt_*                        in-order commit of one uop
//   flush                        squash all uncommitted state
//   fl_count                     free entries visible to the speculative head
module rename_in_receiver #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int ARCH_W    = 5,
  parameter int PHYS_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ARCH_W-1:0] in_rs1,
  input  logic [ARCH_W-1:0] in_rs2,
  input  logic [ARCH_W-1:0] in_rd,
  input  logic              in_rd_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PHYS_W-1:0] out_prs1,
  output logic [PHYS_W-1:0] out_prs2,
  output logic [PHYS_W-1:0] out_prd,
  output logic [PHYS_W-1:0] out_old_prd,
  output logic              out_rd_wen,
  input  logic              cmt_valid,
  input  logic              cmt_rd_wen,
  input  logic [ARCH_W-1:0] cmt_rd,
  input  logic [PHYS_W-1:0] cmt_prd,
  input  logic [PHYS_W-1:0] cmt_old_prd,
  input  logic              flush,
  output logic [PHYS_W:0]   fl_count
);

  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FL_AW    = $clog2(FL_DEPTH);
  localparam int PTR_W    = FL_AW + 1;

  logic [PHYS_W-1:0] spec_rat [ARCH_REGS];
  logic [PHYS_W-1:0] cmt_rat  [ARCH_REGS];
  logic [PHYS_W-1:0] fl       [FL_DEPTH];

  // Pointers carry a wrap bit so full (tail-head == FL_DEPTH) and empty differ.
  logic [PTR_W-1:0] spec_head;
  logic [PTR_W-1:0] cmt_head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] fl_diff;

  logic eff_wen;
  logic accept;
  logic alloc;
  logic cmt_do;

  assign fl_diff  = tail - spec_head;
  assign fl_count = (PHYS_W+1)'(fl_diff);

  assign eff_wen  = in_rd_wen && (in_rd != '0);
  // Ready also requires a free entry for non-writing uops; keeps the rule simple.
  assign in_ready = (!out_valid || out_ready) && !flush && (fl_diff != '0);
  assign accept   = in_valid && in_ready;
  assign alloc    = accept && eff_wen;
  assign cmt_do   = cmt_valid && cmt_rd_wen && (cmt_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat[i] <= PHYS_W'(i);
        cmt_rat[i]  <= PHYS_W'(i);
      end
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl[i] <= PHYS_W'(ARCH_REGS + i);
      end
      spec_head   <= '0;
      cmt_head    <= '0;
      tail        <= PTR_W'(FL_DEPTH);
      out_valid   <= 1'b0;
      out_prs1    <= '0;
      out_prs2    <= '0;
      out_prd     <= '0;
      out_old_prd <= '0;
      out_rd_wen  <= 1'b0;
    end else begin
      if (cmt_do) begin
        cmt_rat[cmt_rd]     <= cmt_prd;
        fl[tail[FL_AW-1:0]] <= cmt_old_prd;
        tail                <= tail + PTR_W'(1);
        cmt_head            <= cmt_head + PTR_W'(1);
      end

      if (flush) begin
        // Restore sees this cycle's commit as if it had already landed.
        for (int i = 0; i < ARCH_REGS; i++) begin
          spec_rat[i] <= (cmt_do && (cmt_rd == ARCH_W'(i))) ? cmt_prd : cmt_rat[i];
        end
        spec_head <= cmt_head + PTR_W'(cmt_do);
      end else if (alloc) begin
        spec_rat[in_rd] <= fl[spec_head[FL_AW-1:0]];
        spec_head       <= spec_head + PTR_W'(1);
      end

      if (accept) begin
        out_valid   <= 1'b1;
        out_prs1    <= spec_rat[in_rs1];
        out_prs2    <= spec_rat[in_rs2];
        out_old_prd <= spec_rat[in_rd];
        out_prd     <= eff_wen ? fl[spec_head[FL_AW-1:0]] : '0;
        out_rd_wen  <= eff_wen;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rename_in_receiver.sv
// tb_rename_in_receiver
// Directed bench for rename_in_receiver. Inputs change 1 time unit after
// the rising edge; outputs are sampled there as well.
module tb_rename_in_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [4:0] in_rs1, in_rs2, in_rd;
  logic       in_rd_wen;
  logic       out_valid, out_ready;
  logic [5:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic       out_rd_wen;
  logic       cmt_valid, cmt_rd_wen;
  logic [4:0] cmt_rd;
  logic [5:0] cmt_prd, cmt_old_prd;
  logic       flush;
  logic [6:0] fl_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rename_in_receiver dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_old_prd(out_old_prd), .out_rd_wen(out_rd_wen),
    .cmt_valid(cmt_valid), .cmt_rd_wen(cmt_rd_wen), .cmt_rd(cmt_rd),
    .cmt_prd(cmt_prd), .cmt_old_prd(cmt_old_prd),
    .flush(flush), .fl_count(fl_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic wen);
    in_valid  = v;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd_wen = wen;
  endtask

  task automatic drive_cmt(input logic v, input logic [4:0] rd, input logic [5:0] prd,
                           input logic [5:0] old);
    cmt_valid   = v;
    cmt_rd_wen  = v;
    cmt_rd      = rd;
    cmt_prd     = prd;
    cmt_old_prd = old;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  // Protocol guard: a commit that would push the free list past full.
  always @(negedge clk) begin
    if (!rst && cmt_valid && cmt_rd_wen && cmt_rd != 0 && fl_count == 7'd32 &&
        !(in_valid && in_ready && in_rd_wen && in_rd != 0)) begin
      n_chk++;
      $display("FAIL fl_overflow: got count %0d with a free, expected below 32", fl_count);
    end
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    flush = 1'b0;
    drive_in(0, 0, 0, 0, 0);
    drive_cmt(0, 0, 0, 0);
    do_reset();

    chk("rst_out_valid", out_valid, 0);
    chk("rst_fl_count", fl_count, 32);
    chk("rst_out_prd", out_prd, 0);
    chk("rst_in_ready", in_ready, 1);

    // Basic rename chain on rd=3
    drive_in(1, 3, 3, 0, 1);
    tick();
    chk("a1_valid", out_valid, 1);
    chk("a1_prd", out_prd, 32);
    chk("a1_old", out_old_prd, 3);
    chk("a1_prs1", out_prs1, 3);
    chk("a1_prs2", out_prs2, 0);
    chk("a1_wen", out_rd_wen, 1);
    chk("a1_cnt", fl_count, 31);
    drive_in(1, 3, 3, 0, 1);
    tick();
    chk("a2_prd", out_prd, 33);
    chk("a2_old", out_old_prd, 32);
    chk("a2_prs1", out_prs1, 32);
    chk("a2_cnt", fl_count, 30);

    // rd=x0 never allocates
    drive_in(1, 0, 0, 0, 1);
    tick();
    chk("x0_wen", out_rd_wen, 0);
    chk("x0_prd", out_prd, 0);
    chk("x0_old", out_old_prd, 0);
    chk("x0_cnt", fl_count, 30);

    // Drain, then stall the output stage for 3 cycles
    drive_in(0, 0, 0, 0, 0);
    tick();
    chk("drain_valid", out_valid, 0);
    out_ready = 1'b0;
    drive_in(1, 7, 3, 3, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_prd", out_prd, 34);
      chk("stall_old", out_old_prd, 7);
      chk("stall_prs1", out_prs1, 33);
      chk("stall_ready", in_ready, 0);
      chk("stall_cnt", fl_count, 29);
      if (k < 2) tick();
    end
    out_ready = 1'b1;
    settle();
    chk("release_ready", in_ready, 1);
    tick();
    chk("release_valid", out_valid, 1);
    chk("release_prd", out_prd, 35);
    chk("release_old", out_old_prd, 34);
    chk("release_cnt", fl_count, 28);

    // Reset mid-operation with a valid input pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_in(0, 0, 0, 0, 0);
    settle();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_cnt", fl_count, 32);
    chk("mrst_prd", out_prd, 0);

    // Rename rd=4 twice, commit the first, flush
    drive_in(1, 4, 4, 0, 1);
    tick();
    chk("f1_prd", out_prd, 32);
    chk("f1_old", out_old_prd, 4);
    tick();
    chk("f2_prd", out_prd, 33);
    chk("f2_old", out_old_prd, 32);
    drive_in(0, 0, 0, 0, 0);
    drive_cmt(1, 4, 32, 4);
    tick();
    drive_cmt(0, 0, 0, 0);
    chk("f_cmt_cnt", fl_count, 31);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("f_flush_valid", out_valid, 0);
    chk("f_flush_cnt", fl_count, 32);
    drive_in(1, 4, 4, 0, 1);
    tick();
    chk("f3_prd", out_prd, 33);
    chk("f3_old", out_old_prd, 32);
    chk("f3_prs1", out_prs1, 32);

    // Flush + commit + valid input in one cycle
    drive_in(1, 5, 4, 0, 1);
    drive_cmt(1, 4, 33, 32);
    flush = 1'b1;
    settle();
    chk("fc_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    drive_cmt(0, 0, 0, 0);
    chk("fc_valid", out_valid, 0);
    chk("fc_cnt", fl_count, 32);
    tick();
    chk("fc_next_valid", out_valid, 1);
    chk("fc_next_prs1", out_prs1, 33);
    chk("fc_next_prd", out_prd, 34);
    chk("fc_next_old", out_old_prd, 5);
    drive_in(0, 0, 0, 0, 0);

    // Exhaust the free list
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive_in(1, 5'(((i + 4) % 31) + 1), 0, 0, 1);
      settle();
      chk("full_ready", in_ready, 1);
      tick();
    end
    chk("full_last_prd", out_prd, 63);
    chk("full_last_old", out_old_prd, 32);
    chk("full_cnt", fl_count, 0);
    chk("full_ready0", in_ready, 0);
    drive_in(1, 9, 0, 0, 1);
    drive_cmt(1, 5, 32, 5);
    settle();
    chk("full_cmt_ready", in_ready, 0);
    tick();
    drive_cmt(0, 0, 0, 0);
    chk("full_noacc_valid", out_valid, 0);
    chk("full_free_cnt", fl_count, 1);
    chk("full_free_ready", in_ready, 1);
    tick();
    chk("reuse_valid", out_valid, 1);
    chk("reuse_prd", out_prd, 5);
    chk("reuse_old", out_old_prd, 36);
    chk("reuse_cnt", fl_count, 0);
    drive_in(0, 0, 0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
